// File: rtl/ahb_apb_bridge_gen.sv
// -----------------------------------------------------------------------------
// ahb_apb_bridge_gen
// Parametrised AHB-to-APB bridge. One AHB slave port fans out to NUM_SLV APB
// slaves with a one-hot psel. Handles APB wait states, APB slave errors
// (turned into a two-cycle AHB ERROR), address decode misses and an optional
// ACCESS-phase timeout.
//
// Ports
//   hclk, hresetn        clock, asynchronous active-low reset
//   hwrite, hready_in,   AHB address-phase controls
//   htrans, haddr
//   hwdata               AHB write data (data phase)
//   hrdata               AHB read data, registered
//   hreadyout, hresp     AHB handshake back to the master
//   psel, penable,       APB controls (psel is one-hot)
//   pwrite
//   paddr, pwdata        APB address / write data, registered
//   prdata, pready,      APB response from the selected slave
//   pslverr
// -----------------------------------------------------------------------------
module ahb_apb_bridge_gen #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 3,
   parameter int SEL_LSB = 28,
   parameter int TIMEOUT = 0
) (
   input  logic               hclk,
   input  logic               hresetn,
   input  logic               hwrite,
   input  logic               hready_in,
   input  logic [1:0]         htrans,
   input  logic [ADDR_W-1:0]  haddr,
   input  logic [DATA_W-1:0]  hwdata,
   output logic [DATA_W-1:0]  hrdata,
   output logic               hreadyout,
   output logic [1:0]         hresp,
   output logic [NUM_SLV-1:0] psel,
   output logic               penable,
   output logic               pwrite,
   output logic [ADDR_W-1:0]  paddr,
   output logic [DATA_W-1:0]  pwdata,
   input  logic [DATA_W-1:0]  prdata,
   input  logic               pready,
   input  logic               pslverr
);

   localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   // Slave count widened by one bit so every index value can be compared.
   localparam logic [SEL_W:0]   NUM_SLV_V = (SEL_W + 1)'(NUM_SLV);
   // Count value seen during the last permitted ACCESS cycle.
   localparam logic [CNT_W-1:0] TO_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WDATA  = 3'd1;
   localparam logic [2:0] ST_SETUP  = 3'd2;
   localparam logic [2:0] ST_ACCESS = 3'd3;
   localparam logic [2:0] ST_ERR1   = 3'd4;
   localparam logic [2:0] ST_ERR2   = 3'd5;

   logic [2:0]        state_q,  state_d;
   logic [SEL_W-1:0]  idx_q,    idx_d;
   logic [ADDR_W-1:0] paddr_q,  paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] hrdata_q, hrdata_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;

   logic [SEL_W-1:0]  haddr_idx;
   logic              addr_hit;
   logic              xfer_valid;

   assign haddr_idx  = haddr[SEL_LSB +: SEL_W];
   assign addr_hit   = {1'b0, haddr_idx} < NUM_SLV_V;
   // ERR2 is the second ERROR cycle, in which the master already drives the
   // next address phase, so it samples transfers exactly like IDLE.
   assign xfer_valid = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) &&
                       hready_in && htrans[1];

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      idx_d    = idx_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      hrdata_d = hrdata_q;
      cnt_d    = cnt_q;

      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = ST_IDLE;
            if (xfer_valid) begin
               paddr_d  = haddr;
               pwrite_d = hwrite;
               idx_d    = haddr_idx;
               if (addr_hit) state_d = hwrite ? ST_WDATA : ST_SETUP;
               else          state_d = ST_ERR1;
            end
         end
         ST_WDATA: begin
            pwdata_d = hwdata;
            state_d  = ST_SETUP;
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               if (pslverr) begin
                  state_d = ST_ERR1;
               end else begin
                  if (!pwrite_q) hrdata_d = prdata;
                  state_d = ST_IDLE;
               end
            end else begin
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
               if ((TIMEOUT > 0) && (cnt_q >= TO_LAST)) state_d = ST_ERR1;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The counter restarts for every APB transfer.
      if (state_d == ST_SETUP) cnt_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         hrdata_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
         cnt_q    <= cnt_d;
      end
   end

   // Handshake outputs decode straight from the state register so an
   // asynchronous reset clears them without waiting for a clock edge.
   assign hreadyout = (state_q == ST_IDLE) || (state_q == ST_ERR2);
   assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
   assign penable   = (state_q == ST_ACCESS);

   always_comb begin
      psel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         psel[i] = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) &&
                   (idx_q == SEL_W'(i));
      end
   end

   assign pwrite = pwrite_q;
   assign paddr  = paddr_q;
   assign pwdata = pwdata_q;
   assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_gen.sv
// -----------------------------------------------------------------------------
// tb_ahb_apb_bridge_gen
// Self-checking bench for ahb_apb_bridge_gen (NUM_SLV=3, TIMEOUT=8).
// A transaction-level model holds the APB slave memories and the expected
// AHB/APB handshake for every cycle of each transfer.
// -----------------------------------------------------------------------------
module tb_ahb_apb_bridge_gen;

   localparam int NUM_SLV = 3;
   localparam int TIMEOUT = 8;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hwrite;
   logic        hready_in;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic [1:0]  hresp;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   ahb_apb_bridge_gen #(
      .ADDR_W (32),
      .DATA_W (32),
      .NUM_SLV(NUM_SLV),
      .SEL_LSB(28),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .hwrite   (hwrite),
      .hready_in(hready_in),
      .htrans   (htrans),
      .haddr    (haddr),
      .hwdata   (hwdata),
      .hrdata   (hrdata),
      .hreadyout(hreadyout),
      .hresp    (hresp),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr)
   );

   always #5 hclk = ~hclk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [31:0] mem [0:NUM_SLV-1][0:15];
   logic [31:0] hrdata_exp;
   logic [31:0] last_addr;
   logic [31:0] last_wdata;
   logic [1:0]  resp_exp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bus(input string tag, input logic rdy, input logic [1:0] rsp,
                            input logic [2:0] sel, input logic en);
      check({tag, ".hreadyout"}, hreadyout, rdy);
      check({tag, ".hresp"},     hresp,     rsp);
      check({tag, ".psel"},      psel,      sel);
      check({tag, ".penable"},   penable,   en);
   endtask

   task automatic check_apb(input string tag, input logic [31:0] addr, input logic wr);
      check({tag, ".paddr"},  paddr,  addr);
      check({tag, ".pwrite"}, pwrite, wr);
      check({tag, ".pwdata"}, pwdata, last_wdata);
   endtask

   // Checks made in any cycle where the bridge should be ready for a new
   // address phase (IDLE or second ERROR cycle).
   task automatic check_ready(input string tag);
      check_bus(tag, 1'b1, resp_exp, 3'b000, 1'b0);
      check({tag, ".hrdata"}, hrdata, hrdata_exp);
      check({tag, ".paddr"},  paddr,  last_addr);
      check({tag, ".pwdata"}, pwdata, last_wdata);
   endtask

   // Advance one cycle; inputs not under test get noise that must be ignored.
   task automatic step();
      @(posedge hclk);
      #1;
      htrans    = 2'($urandom_range(0, 1));
      hready_in = 1'($urandom_range(0, 1));
      hwrite    = 1'($urandom_range(0, 1));
      haddr     = $urandom;
      hwdata    = $urandom;
      prdata    = $urandom;
      pready    = 1'b0;
      pslverr   = 1'b0;
   endtask

   // One ready cycle with no valid transfer (IDLE, BUSY, or NONSEQ while
   // hready_in is low).
   task automatic idle_cycle();
      int kind;
      kind      = $urandom_range(0, 2);
      htrans    = (kind == 0) ? 2'b00 : ((kind == 1) ? 2'b01 : 2'b10);
      hready_in = (kind == 2) ? 1'b0 : 1'b1;
      @(negedge hclk);
      check_ready("idle");
      resp_exp = 2'b00;
      step();
   endtask

   // One AHB transfer, entered and left at the start of a ready cycle.
   // waits = ACCESS cycles with pready low before the slave answers.
   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic err);
      int       idx;
      int       word;
      int       k;
      bit       done;
      bit       ok;
      logic [2:0] oh;
      idx  = int'(addr[29:28]);
      word = int'(addr[5:2]);
      htrans    = 2'b10;
      hready_in = 1'b1;
      hwrite    = wr;
      haddr     = addr;
      @(negedge hclk);
      check_ready("addr");
      last_addr = addr;
      if (idx >= NUM_SLV) begin
         step();
         @(negedge hclk);
         check_bus("miss", 1'b0, 2'b01, 3'b000, 1'b0);
         resp_exp = 2'b01;
      end else begin
         oh = 3'b001 << idx;
         if (wr) begin
            step();
            hwdata = wdata;
            @(negedge hclk);
            check_bus("wdata", 1'b0, 2'b00, 3'b000, 1'b0);
            last_wdata = wdata;
         end
         step();
         @(negedge hclk);
         check_bus("setup", 1'b0, 2'b00, oh, 1'b0);
         check_apb("setup", addr, wr);
         k    = 0;
         done = 0;
         ok   = 0;
         while (!done) begin
            step();
            if (k == waits) begin
               pready  = 1'b1;
               pslverr = err;
               if (!wr) prdata = mem[idx][word];
            end
            @(negedge hclk);
            check_bus("access", 1'b0, 2'b00, oh, 1'b1);
            check_apb("access", addr, wr);
            if (k == waits) begin
               done = 1;
               ok   = !err;
            end else if (k == TIMEOUT - 1) begin
               done = 1;
            end
            k++;
         end
         if (ok) begin
            if (wr) mem[idx][word] = wdata;
            else    hrdata_exp     = mem[idx][word];
            resp_exp = 2'b00;
         end else begin
            step();
            @(negedge hclk);
            check_bus("err1", 1'b0, 2'b01, 3'b000, 1'b0);
            resp_exp = 2'b01;
         end
      end
      step();
   endtask

   initial begin
      logic [31:0] a;
      int          w;

      hresetn   = 1'b0;
      hwrite    = 1'b0;
      hready_in = 1'b1;
      htrans    = 2'b00;
      haddr     = '0;
      hwdata    = '0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      for (int s = 0; s < NUM_SLV; s++)
         for (int i = 0; i < 16; i++) mem[s][i] = $urandom;
      mem[1][1]  = 32'hCAFE_F00D;
      hrdata_exp = '0;
      last_addr  = '0;
      last_wdata = '0;
      resp_exp   = 2'b00;

      // Reset values, before any clock edge.
      #1;
      check_ready("reset");
      check("reset.pwrite", pwrite, 1'b0);
      @(posedge hclk);
      #1;
      hresetn = 1'b1;

      // Directed read to slave 1.
      do_xfer(1'b0, 32'h1000_0004, '0, 0, 1'b0);
      idle_cycle();
      // Write to slave 2 with three wait states, then read it back.
      do_xfer(1'b1, 32'h2000_0010, 32'h1234_5678, 3, 1'b0);
      do_xfer(1'b0, 32'h2000_0010, '0, 0, 1'b0);
      idle_cycle();
      // Slave error on a write: ERROR pair, then IDLE with OKAY.
      do_xfer(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1, 1'b1);
      idle_cycle();
      idle_cycle();
      // Decode miss.
      do_xfer(1'b0, 32'h3000_0000, '0, 0, 1'b0);
      idle_cycle();
      idle_cycle();
      // Timeout: pready never arrives; then the last cycle that still completes.
      do_xfer(1'b0, 32'h0000_0040, '0, 1000, 1'b0);
      idle_cycle();
      do_xfer(1'b0, 32'h1000_0008, '0, TIMEOUT - 1, 1'b0);
      idle_cycle();
      // Back-to-back: read then write with no idle cycle, and a new transfer
      // taken directly in the second ERROR cycle.
      do_xfer(1'b0, 32'h1000_0004, '0, 0, 1'b0);
      do_xfer(1'b1, 32'h0000_000C, 32'hA5A5_5A5A, 0, 1'b0);
      do_xfer(1'b0, 32'h3000_0004, '0, 0, 1'b0);
      do_xfer(1'b0, 32'h0000_000C, '0, 2, 1'b0);
      idle_cycle();

      // Asynchronous reset in the middle of an ACCESS phase.
      htrans    = 2'b10;
      hready_in = 1'b1;
      hwrite    = 1'b0;
      haddr     = 32'h1000_0008;
      step();
      step();
      @(negedge hclk);
      check("rst.penable_before", penable, 1'b1);
      #2;
      hresetn = 1'b0;
      #1;
      hrdata_exp = '0;
      last_addr  = '0;
      last_wdata = '0;
      resp_exp   = 2'b00;
      check_ready("rst_mid");
      @(posedge hclk);
      #1;
      hresetn = 1'b1;
      htrans  = 2'b00;

      // Randomised traffic against the model.
      for (int n = 0; n < 80; n++) begin
         a = {2'($urandom), 2'($urandom_range(0, 3)), 22'($urandom), 4'($urandom), 2'b00};
         w = ($urandom_range(0, 7) == 0) ? TIMEOUT + $urandom_range(0, 2)
                                         : $urandom_range(0, 3);
         do_xfer(1'($urandom_range(0, 1)), a, $urandom, w,
                 1'($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 2) == 0) idle_cycle();
      end
      idle_cycle();
      idle_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
